// File: rtl/tluh_pkg.sv
// tluh_pkg: TL-UH logical-op encodings and the RMW engine state enum.
// Contents: tluh_a_param_log (A-channel param for LogicalData), the
// XOR/OR/AND/SWAP encodings, rmw_state_e, and op_valid() for legal ops.
package tluh_pkg;

    typedef logic [2:0] tluh_a_param_log;

    localparam tluh_a_param_log LOG_XOR  = 3'd0;
    localparam tluh_a_param_log LOG_OR   = 3'd1;
    localparam tluh_a_param_log LOG_AND  = 3'd2;
    localparam tluh_a_param_log LOG_SWAP = 3'd3;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        RSP
    } rmw_state_e;

    function automatic logic op_valid(input tluh_a_param_log op);
        return op <= LOG_SWAP;
    endfunction

endpackage

// File: rtl/tluh_logic_rmw_logical_unit.sv
// logical_unit: combinational TL-UH logical operation.
// Ports: a (request data), b (old memory value), op (logical param),
//        y (value to write back).
module logical_unit
    import tluh_pkg::*;
(
    input  logic [31:0]     a,
    input  logic [31:0]     b,
    input  tluh_a_param_log op,
    output logic [31:0]     y
);

    always_comb y = op == LOG_XOR ? a ^ b :
                    op == LOG_OR  ? a | b :
                    op == LOG_AND ? a & b : a;

endmodule

// File: rtl/tluh_logic_rmw.sv
// tluh_logic_rmw: TL-UH LogicalData read-modify-write engine, one op in flight.
// Ports: clk_i/rst_i (sync active-high reset); req_* request handshake and
//        fields; mem_* single-port memory request/grant/read-data channel;
//        rsp_* response handshake with old value, source and error.
// Option: TLUH_RMW_MEM_ERR_EN adds mem_err_i, sampled with mem_rvalid_i.
module tluh_logic_rmw
    import tluh_pkg::*;
#(
    parameter int SRC_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [31:0]      req_addr_i,
    input  logic [31:0]      req_data_i,
    input  logic [3:0]       req_mask_i,
    input  logic [SRC_W-1:0] req_source_i,
    input  tluh_a_param_log  req_op_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    output logic [3:0]       mem_be_o,
    input  logic             mem_gnt_i,
    input  logic             mem_rvalid_i,
    input  logic [31:0]      mem_rdata_i,
`ifdef TLUH_RMW_MEM_ERR_EN
    input  logic             mem_err_i,
`endif
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_data_o,
    output logic [SRC_W-1:0] rsp_source_o,
    output logic             rsp_error_o
);

    rmw_state_e       state, nxt;
    logic [31:0]      addr, data, old, result;
    logic [3:0]       mask;
    logic [SRC_W-1:0] source;
    tluh_a_param_log  op;
    logic             err, mem_err, accept, bad;

`ifdef TLUH_RMW_MEM_ERR_EN
    assign mem_err = mem_err_i;
`else
    assign mem_err = 1'b0;
`endif

    assign accept = req_valid_i && req_ready_o;
    // Illegal ops and empty masks are answered with an error, never touching memory
    assign bad    = !op_valid(req_op_i) || req_mask_i == 4'h0;

    logical_unit u_lu (
        .a  (data),
        .b  (old),
        .op (op),
        .y  (result)
    );

    assign mem_addr_o   = addr & 32'hFFFF_FFFC;
    assign rsp_data_o   = old;
    assign rsp_source_o = source;
    assign rsp_error_o  = err;

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt         = state;
        req_ready_o = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_wdata_o = 32'h0;
        rsp_valid_o = 1'b0;
        case (state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) nxt = bad ? RSP : RD_REQ;
            end
            RD_REQ: begin
                mem_req_o = 1'b1;
                mem_be_o  = 4'hF;
                if (mem_gnt_i) nxt = RD_WAIT;
            end
            RD_WAIT: if (mem_rvalid_i) nxt = mem_err ? RSP : WR_REQ;
            WR_REQ: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_be_o    = mask;
                mem_wdata_o = result;
                if (mem_gnt_i) nxt = WR_WAIT;
            end
            WR_WAIT: if (mem_rvalid_i) nxt = RSP;
            RSP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr   <= '0;
            data   <= '0;
            mask   <= '0;
            source <= '0;
            op     <= LOG_XOR;
            old    <= '0;
            err    <= 1'b0;
        end else begin
            if (accept) begin
                addr   <= req_addr_i;
                data   <= req_data_i;
                mask   <= req_mask_i;
                source <= req_source_i;
                op     <= req_op_i;
                old    <= '0;
                err    <= bad;
            end
            // A failed read reports zero data; a failed write keeps the old value
            if (state == RD_WAIT && mem_rvalid_i) begin
                old <= mem_err ? 32'h0 : mem_rdata_i;
                err <= mem_err;
            end
            if (state == WR_WAIT && mem_rvalid_i) err <= mem_err;
        end
    end

endmodule
